// File: rtl/tile_grid_renderer.sv
// Double-buffered GRID_N x GRID_N tile board renderer with a 2-stage pixel pipeline.
// Optional per-tile change flash is enabled by defining TILE_FLASH_EN.
module tile_grid_renderer #(
  parameter int GRID_N   = 4,
  parameter int IDX_W    = 3,
  parameter int TILE_DIM = 64,
  parameter int MARGIN   = 10,
  parameter int X_OFF    = 40,
  parameter int Y_OFF    = 0,
  parameter int VAL_W    = 4
`ifdef TILE_FLASH_EN
  , parameter int FLASH_FRAMES = 8
`endif
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [9:0]       iPX,
  input  logic [9:0]       iPY,
  input  logic             iFRAME_START,
  input  logic             iWR_VALID,
  input  logic [IDX_W-1:0] iWR_ROW,
  input  logic [IDX_W-1:0] iWR_COL,
  input  logic [VAL_W-1:0] iWR_VAL,
  output logic             oWR_READY,
  input  logic             iCLEAR,
  output logic [9:0]       oR,
  output logic [9:0]       oG,
  output logic [9:0]       oB
);

  localparam int PITCH  = TILE_DIM + MARGIN;
  localparam int BOARD  = MARGIN + GRID_N * PITCH;
  localparam int CELLS  = GRID_N * GRID_N;
  localparam int CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(CELLS - 1);
  localparam logic [29:0] RGB_GAP = {10'h100, 10'h100, 10'h100};

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {REG_BG, REG_GAP, REG_TILE} region_t;

  state_t                         state_q, state_d;
  logic [CELL_W-1:0]              clr_idx_q, clr_idx_d;
  logic                           pending_q, pending_d;
  logic [CELLS-1:0][VAL_W-1:0]    shadow_q, shadow_d;
  logic [CELLS-1:0][VAL_W-1:0]    display_q, display_d;
  logic                           commit;
  region_t                        region_q, region_d;
  logic [IDX_W-1:0]               row_q, row_d, col_q, col_d;
  logic [29:0]                    rgb_q, rgb_d;
  int                             rx, ry;
  logic                           in_x, in_y, tile_x, tile_y;
  logic [CELL_W-1:0]              rd_idx;

  function automatic logic [29:0] palette(input logic [VAL_W-1:0] v);
    logic [29:0] c;
    case (int'(v))
      0:       c = {10'h0C0, 10'h0C0, 10'h0C0};
      1:       c = {10'h000, 10'h3FF, 10'h3FF};
      2:       c = {10'h3FF, 10'h000, 10'h3FF};
      3:       c = {10'h3FF, 10'h3FF, 10'h000};
      4:       c = {10'h000, 10'h000, 10'h3FF};
      default: c = {10'h3FF, 10'h3FF, 10'h3FF};
    endcase
    return c;
  endfunction

  // Write/clear control and frame-start commit of the shadow grid into the display grid.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    commit    = 1'b0;
    oWR_READY = 1'b0;
    case (state_q)
      IDLE: begin
        oWR_READY = iRST_N & ~iFRAME_START & ~iCLEAR;
        if (iCLEAR) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (iWR_VALID && oWR_READY &&
                     int'(iWR_ROW) < GRID_N && int'(iWR_COL) < GRID_N) begin
          shadow_d[CELL_W'(int'(iWR_ROW) * GRID_N + int'(iWR_COL))] = iWR_VAL;
        end
        if (iFRAME_START) begin
          display_d = shadow_q;
          commit    = 1'b1;
        end
      end
      CLEAR: begin
        shadow_d[clr_idx_q] = '0;
        clr_idx_d = clr_idx_q + CELL_W'(1);
        if (iFRAME_START) pending_d = 1'b1;
        if (clr_idx_q == LAST_CELL) begin
          state_d   = IDLE;
          clr_idx_d = '0;
          pending_d = 1'b0;
          if (pending_q || iFRAME_START) begin
            display_d = shadow_d;
            commit    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: classify the pixel as background, gap or tile and locate the tile.
  always_comb begin
    rx       = int'(iPX) - (X_OFF + MARGIN);
    ry       = int'(iPY) - (Y_OFF + MARGIN);
    in_x     = int'(iPX) >= X_OFF && int'(iPX) < X_OFF + BOARD;
    in_y     = int'(iPY) >= Y_OFF && int'(iPY) < Y_OFF + BOARD;
    tile_x   = rx >= 0 && (rx % PITCH) < TILE_DIM && (rx / PITCH) < GRID_N;
    tile_y   = ry >= 0 && (ry % PITCH) < TILE_DIM && (ry / PITCH) < GRID_N;
    region_d = REG_BG;
    row_d    = '0;
    col_d    = '0;
    if (in_x && in_y) begin
      region_d = REG_GAP;
      if (tile_x && tile_y) begin
        region_d = REG_TILE;
        row_d    = IDX_W'(ry / PITCH);
        col_d    = IDX_W'(rx / PITCH);
      end
    end
  end

`ifdef TILE_FLASH_EN
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  logic [CELLS-1:0][FL_W-1:0] flash_q, flash_d;

  // Changed tiles restart their flash countdown; every frame start ticks the rest down.
  always_comb begin
    flash_d = flash_q;
    for (int i = 0; i < CELLS; i++) begin
      if (commit && display_d[i] != display_q[i])
        flash_d[i] = FL_W'(FLASH_FRAMES);
      else if (iFRAME_START && flash_q[i] != '0)
        flash_d[i] = flash_q[i] - FL_W'(1);
    end
  end
`endif

  // Stage 2: look up the display grid and map through the palette.
  always_comb begin
    rd_idx = CELL_W'(int'(row_q) * GRID_N + int'(col_q));
    case (region_q)
      REG_TILE: rgb_d = palette(display_q[rd_idx]);
      REG_GAP:  rgb_d = RGB_GAP;
      default:  rgb_d = '0;
    endcase
`ifdef TILE_FLASH_EN
    if (region_q == REG_TILE && flash_q[rd_idx] != '0) rgb_d = ~rgb_d;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      display_q <= '0;
      region_q  <= REG_BG;
      row_q     <= '0;
      col_q     <= '0;
      rgb_q     <= '0;
`ifdef TILE_FLASH_EN
      flash_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      region_q  <= region_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rgb_q     <= rgb_d;
`ifdef TILE_FLASH_EN
      flash_q   <= flash_d;
`endif
    end
  end

  assign oR = rgb_q[29:20];
  assign oG = rgb_q[19:10];
  assign oB = rgb_q[9:0];

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed, table-driven bench for tile_grid_renderer (default geometry, 4x4 board).
module tb_tile_grid_renderer;

  localparam logic [29:0] C_BG    = 30'h0;
  localparam logic [29:0] C_GAP   = {10'h100, 10'h100, 10'h100};
  localparam logic [29:0] C_GREY  = {10'h0C0, 10'h0C0, 10'h0C0};
  localparam logic [29:0] C_MAG   = {10'h3FF, 10'h000, 10'h3FF};
  localparam logic [29:0] C_YEL   = {10'h3FF, 10'h3FF, 10'h000};
  localparam logic [29:0] C_BLUE  = {10'h000, 10'h000, 10'h3FF};
  localparam logic [29:0] C_WHITE = {10'h3FF, 10'h3FF, 10'h3FF};

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [9:0] iPX = '0, iPY = '0;
  logic       iFRAME_START = 1'b0;
  logic       iWR_VALID = 1'b0;
  logic [2:0] iWR_ROW = '0, iWR_COL = '0;
  logic [3:0] iWR_VAL = '0;
  logic       oWR_READY;
  logic       iCLEAR = 1'b0;
  logic [9:0] oR, oG, oB;

  int checks = 0;
  int errors = 0;

  tile_grid_renderer dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iPX(iPX), .iPY(iPY),
    .iFRAME_START(iFRAME_START), .iWR_VALID(iWR_VALID),
    .iWR_ROW(iWR_ROW), .iWR_COL(iWR_COL), .iWR_VAL(iWR_VAL),
    .oWR_READY(oWR_READY), .iCLEAR(iCLEAR),
    .oR(oR), .oG(oG), .oB(oB)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          x;
    int          y;
    logic [29:0] rgb;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int x, input int y);
    iPX = 10'(x);
    iPY = 10'(y);
    @(posedge iCLK);
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic check_pixel(input string name, input int x, input int y, input logic [29:0] exp);
    applyStimulus(x, y);
    checkOutput(name, {oR, oG, oB}, exp);
  endtask

  task automatic write_tile(input int row, input int col, input int val);
    iWR_VALID = 1'b1;
    iWR_ROW   = 3'(row);
    iWR_COL   = 3'(col);
    iWR_VAL   = 4'(val);
    @(negedge iCLK);
    iWR_VALID = 1'b0;
  endtask

  task automatic frame_pulse();
    iFRAME_START = 1'b1;
    @(negedge iCLK);
    iFRAME_START = 1'b0;
  endtask

  initial begin
    int low_cnt;

    vecs[0]  = '{50, 10, C_GREY};
    vecs[1]  = '{5, 5, C_BG};
    vecs[2]  = '{55, 5, C_GAP};
    vecs[3]  = '{113, 73, C_GREY};
    vecs[4]  = '{114, 10, C_GAP};
    vecs[5]  = '{123, 10, C_GAP};
    vecs[6]  = '{345, 305, C_GAP};
    vecs[7]  = '{346, 10, C_BG};
    vecs[8]  = '{40, 0, C_GAP};
    vecs[9]  = '{39, 0, C_BG};
    vecs[10] = '{50, 306, C_BG};
    vecs[11] = '{272, 232, C_GREY};
    vecs[12] = '{335, 295, C_GREY};
    vecs[13] = '{336, 295, C_GAP};

    // Reset values while iRST_N is held low.
    repeat (3) @(negedge iCLK);
    #1;
    checkOutput("reset_rgb", {oR, oG, oB}, C_BG);
    checkOutput("reset_ready", {29'b0, oWR_READY}, 30'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    #1;
    checkOutput("idle_ready", {29'b0, oWR_READY}, 30'd1);

    // Geometry table with an all-zero display grid.
    for (int i = 0; i < 14; i++)
      check_pixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].rgb);

    // Write (0,1)=2; invisible until the frame commit, then exact 2-cycle latency.
    write_tile(0, 1, 2);
    check_pixel("precommit_01", 124, 10, C_GREY);
    frame_pulse();
    check_pixel("tile00_after_commit", 50, 10, C_GREY);
    iPX = 10'd124;
    iPY = 10'd10;
    @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("latency_1cycle", {oR, oG, oB}, C_GREY);
    @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("latency_2cycle", {oR, oG, oB}, C_MAG);

    // Write held across a frame start: stalled that cycle, taken next, not in that commit.
    iWR_VALID = 1'b1; iWR_ROW = 3'd0; iWR_COL = 3'd2; iWR_VAL = 4'd3;
    iFRAME_START = 1'b1;
    #1;
    checkOutput("ready_in_frame", {29'b0, oWR_READY}, 30'd0);
    @(negedge iCLK);
    iFRAME_START = 1'b0;
    #1;
    checkOutput("ready_after_frame", {29'b0, oWR_READY}, 30'd1);
    @(negedge iCLK);
    iWR_VALID = 1'b0;
    check_pixel("held_write_absent", 198, 10, C_GREY);
    frame_pulse();
    check_pixel("held_write_next", 198, 10, C_YEL);

    // Fill with 1, clear, frame starts mid-clear; commit waits for the clear to finish.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_tile(r, c, 1);
    iCLEAR = 1'b1;
    @(negedge iCLK);
    iCLEAR = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (!oWR_READY) low_cnt++;
      if (i == 5 || i == 8) iFRAME_START = 1'b1;
      if (i == 6 || i == 9) iFRAME_START = 1'b0;
      if (i == 7) begin
        iPX = 10'd124;
        iPY = 10'd10;
      end
      if (i == 9) checkOutput("no_early_commit", {oR, oG, oB}, C_MAG);
      @(negedge iCLK);
    end
    #1;
    checkOutput("clear_ready_low_cnt", 30'(low_cnt), 30'd16);
    checkOutput("ready_after_clear", {29'b0, oWR_READY}, 30'd1);
    check_pixel("cleared_01", 124, 10, C_GREY);
    check_pixel("cleared_33", 272, 232, C_GREY);
    check_pixel("cleared_20", 50, 158, C_GREY);

    // Out-of-range row is accepted but dropped; value >= 5 renders white.
    iWR_VALID = 1'b1; iWR_ROW = 3'd5; iWR_COL = 3'd0; iWR_VAL = 4'd4;
    #1;
    checkOutput("oob_ready", {29'b0, oWR_READY}, 30'd1);
    @(negedge iCLK);
    iWR_VALID = 1'b0;
    frame_pulse();
    check_pixel("oob_no_alias_10", 50, 84, C_GREY);
    check_pixel("oob_no_alias_00", 50, 10, C_GREY);
    write_tile(1, 1, 9);
    frame_pulse();
    check_pixel("val9_white", 124, 84, C_WHITE);

    // Reset in the middle of a clear.
    write_tile(2, 2, 4);
    frame_pulse();
    check_pixel("val4_blue", 198, 158, C_BLUE);
    iCLEAR = 1'b1;
    @(negedge iCLK);
    iCLEAR = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    checkOutput("midclear_rst_rgb", {oR, oG, oB}, C_BG);
    checkOutput("midclear_rst_ready", {29'b0, oWR_READY}, 30'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    checkOutput("post_rst_ready", {29'b0, oWR_READY}, 30'd1);
    check_pixel("post_rst_22", 198, 158, C_GREY);
    frame_pulse();
    check_pixel("post_rst_shadow_22", 198, 158, C_GREY);
    check_pixel("post_rst_shadow_11", 124, 84, C_GREY);

`ifdef TILE_FLASH_EN
    // Changed tile (2,3) flashes inverted for 8 frames, normal on the 9th.
    write_tile(2, 3, 3);
    frame_pulse();
    check_pixel("flash_f0", 272, 158, C_BLUE);
    check_pixel("flash_gap", 114, 10, C_GAP);
    check_pixel("flash_other_tile", 50, 10, C_GREY);
    for (int k = 1; k <= 8; k++) begin
      frame_pulse();
      check_pixel($sformatf("flash_f%0d", k), 272, 158, (k < 8) ? C_BLUE : C_YEL);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
